// File: rtl/dco_pkg.sv
// Shared definitions for the digitally controlled oscillator (DCO) and its
// fout divider: state encoding, widths, correction limits and period lookup.
package dco_pkg;

  localparam int CORR_W   = 3;
  localparam int CORR_MAX = 3;
  localparam int PH_W     = 4;

  typedef enum logic [1:0] {
    NOM   = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } dco_state_e;

  typedef logic signed [CORR_W-1:0] corr_t;

  localparam corr_t CORR_HI = corr_t'(CORR_MAX);
  localparam corr_t CORR_LO = corr_t'(-CORR_MAX);

  // Last phase-counter value of a period: one short of nominal when
  // advancing, one beyond nominal when retarding.
  function automatic logic [PH_W-1:0] term_of(input dco_state_e st, input int nom_p);
    case (st)
      SHORT:   term_of = PH_W'(nom_p - 2);
      LONG:    term_of = PH_W'(nom_p);
      default: term_of = PH_W'(nom_p - 1);
    endcase
  endfunction

endpackage

// File: rtl/dco_fdiv.sv
// Output divider: counts idout pulses and toggles fout every DIV_N/2 pulses,
// giving a 50% duty recovered clock one cycle behind the terminal pulse.
module dco_fdiv
  import dco_pkg::*;
#(
  parameter int DIV_N = 8
) (
  input  logic clk_2,
  input  logic rst,
  input  logic idout,
  output logic fout
);

  localparam int HALF  = DIV_N / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fout_q, fout_d;

  // Advance the pulse count on each idout; toggle fout on the last pulse of a half period.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    fout_d = fout_q;
    if (idout) begin
      if (cnt_q == CNT_W'(HALF - 1)) begin
        cnt_d  = '0;
        fout_d = ~fout_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Divider state register.
  always_ff @(posedge clk_2 or posedge rst) begin
    // NOTE: the reset branch sits in the sensitivity list so state clears without a clock; only control/state flops are reset, never wide storage.
    if (rst) begin
      cnt_q  <= '0;
      fout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      cnt_q  <= cnt_d;
      fout_q <= fout_d;
    end
  end

  assign fout = fout_q;

endmodule

// File: rtl/dco_idc.sv
// Increment/decrement DCO. A phase counter sets the idout period; pending
// loop-filter corrections held in a saturating accumulator shorten or
// lengthen one period at a time. The sticky sat_err port and its logic exist
// only when DCO_SAT_FLAG_EN is defined.
module dco_idc
  import dco_pkg::*;
#(
  parameter int NOM_P = 4,
  parameter int DIV_N = 8
) (
  input  logic clk_2,
  input  logic rst,
  input  logic add,
  input  logic sub,
  output logic idout,
  output logic fout
`ifdef DCO_SAT_FLAG_EN
  ,
  output logic sat_err
`endif
);

  dco_state_e       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [PH_W-1:0]  term;
  corr_t            corr_q, corr_d;
  corr_t            corr_base;
  logic             idout_q, idout_d;
  logic             inc, dec, drop;

  assign term = term_of(state_q, NOM_P);

  // Period type is chosen once, at the start of a period, from the accumulated
  // correction; choosing SHORT or LONG consumes one unit toward zero.
  always_comb begin
    state_d   = state_q;
    corr_base = corr_q;
    if (ph_q == '0) begin
      if (corr_q > corr_t'(0)) begin
        state_d   = SHORT;
        corr_base = corr_q - corr_t'(1);
      end else if (corr_q < corr_t'(0)) begin
        state_d   = LONG;
        corr_base = corr_q + corr_t'(1);
      end else begin
        state_d   = NOM;
      end
    end
  end

  // Phase counting, terminal pulse, and request accumulation with saturation;
  // simultaneous add and sub cancel.
  always_comb begin
    inc     = add & ~sub;
    dec     = sub & ~add;
    drop    = (inc && (corr_base == CORR_HI)) || (dec && (corr_base == CORR_LO));
    corr_d  = corr_base;
    if (inc && !drop) begin
      corr_d = corr_base + corr_t'(1);
    end else if (dec && !drop) begin
      corr_d = corr_base - corr_t'(1);
    end
    idout_d = (ph_q == term);
    ph_d    = (ph_q == term) ? '0 : ph_q + PH_W'(1);
  end

  // State, phase, correction and pulse registers; reset abandons the period.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state_q <= NOM;
      ph_q    <= '0;
      corr_q  <= '0;
      idout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      corr_q  <= corr_d;
      idout_q <= idout_d;
    end
  end

  assign idout = idout_q;

`ifdef DCO_SAT_FLAG_EN
  logic sat_q;

  // Sticky record of any request lost to saturation; only reset clears it.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_q | drop;
    end
  end

  assign sat_err = sat_q;
`endif

  dco_fdiv #(
    .DIV_N (DIV_N)
  ) u_fdiv (
    .clk_2 (clk_2),
    .rst   (rst),
    .idout (idout_q),
    .fout  (fout)
  );

endmodule

// File: tb/tb_dco_idc.sv
// Bench for dco_idc: a hand-built vector table from reset, directed period
// scenarios, and random requests against a period-level reference model.
module tb_dco_idc;

  localparam int NOM_P = 4;
  localparam int DIV_N = 8;
  localparam int NTBL  = 34;

  logic clk_2 = 1'b0;
  logic rst   = 1'b1;
  logic add   = 1'b0;
  logic sub   = 1'b0;
  logic idout;
  logic fout;
`ifdef DCO_SAT_FLAG_EN
  logic sat_err;
`endif

  dco_idc #(
    .NOM_P (NOM_P),
    .DIV_N (DIV_N)
  ) dut (
    .clk_2   (clk_2),
    .rst     (rst),
    .add     (add),
    .sub     (sub),
    .idout   (idout),
    .fout    (fout)
`ifdef DCO_SAT_FLAG_EN
    ,
    .sat_err (sat_err)
`endif
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    bit add;
    bit sub;
    bit exp_idout;
    bit exp_fout;
  } vec_t;

  vec_t tbl[NTBL];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int id_q[$];
  int exp_q[$];

  // Reference model: period length, position within period, pending correction.
  int m_pos, m_len, m_corr, m_pulses;
  bit m_idout, m_fout, m_sat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_len = NOM_P; m_corr = 0; m_pulses = 0;
    m_idout = 0; m_fout = 0; m_sat = 0;
  endtask

  task automatic model_clock(input bit a, input bit s);
    int net;
    bit old_id;
    old_id = m_idout;
    if (m_pos == 0) begin
      if (m_corr > 0) begin
        m_len = NOM_P - 1; m_corr--;
      end else if (m_corr < 0) begin
        m_len = NOM_P + 1; m_corr++;
      end else begin
        m_len = NOM_P;
      end
    end
    m_idout = (m_pos == m_len - 1);
    m_pos   = m_idout ? 0 : m_pos + 1;
    net = int'(a) - int'(s);
    if (m_corr + net > 3 || m_corr + net < -3) m_sat = 1;
    else m_corr += net;
    if (old_id) begin
      m_pulses++;
      if (m_pulses == DIV_N / 2) begin
        m_pulses = 0;
        m_fout = !m_fout;
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, compare on the next falling edge.
  task automatic step(input bit a, input bit s);
    add = a;
    sub = s;
    @(posedge clk_2);
    @(negedge clk_2);
    cyc++;
    model_clock(a, s);
    if (idout === 1'b1) id_q.push_back(cyc);
    check("idout", idout, m_idout);
    check("fout", fout, m_fout);
`ifdef DCO_SAT_FLAG_EN
    check("sat_err", sat_err, m_sat);
`endif
  endtask

  // Advance until the model shows a period boundary (the ph==0 cycle).
  task automatic align();
    bit found;
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      step(0, 0);
      found = m_idout;
    end
    check("align_timeout", found, 1);
    id_q.delete();
    id_q.push_back(cyc);
  endtask

  task automatic check_periods(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i + 1 < id_q.size()) check($sformatf("%s_period%0d", name, i), id_q[i+1] - id_q[i], exp_q[i]);
      else check($sformatf("%s_npulses", name), id_q.size(), i + 2);
    end
  endtask

  initial begin
    for (int k = 0; k < NTBL; k++) begin
      int n;
      n = k + 1;
      tbl[k].add       = (n == 22);
      tbl[k].sub       = 1'b0;
      tbl[k].exp_idout = ((n % 4 == 0) && n <= 24) || n == 27 || n == 31;
      tbl[k].exp_fout  = (n >= 17 && n <= 31);
    end

    // Reset state.
    #1;
    check("rst_idout", idout, 0);
    check("rst_fout", fout, 0);
`ifdef DCO_SAT_FLAG_EN
    check("rst_sat_err", sat_err, 0);
`endif
    repeat (3) @(negedge clk_2);
    rst = 1'b0;
    model_reset();

    // Steady state, then a single add at ph=1: periods 4,...,4,3,4; fout falls a cycle early.
    for (int k = 0; k < NTBL; k++) begin
      step(tbl[k].add, tbl[k].sub);
      check($sformatf("tbl_idout[%0d]", k + 1), idout, tbl[k].exp_idout);
      check($sformatf("tbl_fout[%0d]", k + 1), fout, tbl[k].exp_fout);
    end

    // Single sub at ph=1: current period 4, next 5, then 4.
    align();
    step(0, 0);
    step(0, 1);
    repeat (16) step(0, 0);
    exp_q = '{4, 5, 4, 4};
    check_periods("sub");

    // add and sub together cancel.
    align();
    step(0, 0);
    step(1, 1);
    step(1, 1);
    repeat (14) step(0, 0);
    exp_q = '{4, 4, 4, 4};
    check_periods("cancel");

    // Five consecutive adds from ph=1: saturates at +3, one request dropped.
    align();
    step(0, 0);
    repeat (5) step(1, 0);
    repeat (26) step(0, 0);
    exp_q = '{4, 3, 3, 3, 3, 4, 4};
    check_periods("sat");
    check("sat_model_flag", m_sat, 1);

    // Reset at ph=2 with corr=-2: outputs clear at once, no LONG period afterwards.
    align();
    step(0, 1);
    step(0, 1);
    check("pre_rst_corr", m_corr, -2);
    rst = 1'b1;
    #1;
    check("midrst_idout", idout, 0);
    check("midrst_fout", fout, 0);
`ifdef DCO_SAT_FLAG_EN
    check("midrst_sat_err", sat_err, 0);
`endif
    @(posedge clk_2);
    @(negedge clk_2);
    rst = 1'b0;
    model_reset();
    id_q.delete();
    id_q.push_back(cyc);
    repeat (17) step(0, 0);
    exp_q = '{4, 4, 4, 4};
    check_periods("after_rst");

    // Random requests against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
